// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle between pc_gen, inst_if and the backend.
// master = pc_gen (drives fetch address/enable, accept, fault flag);
// slave = environment (drives inst_if stall, backend stall, redirects).
interface pc_gen_if #(
   parameter int XLEN = 64
);
   logic            stall_from_inst_if;
   logic            stall_from_backend;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic [XLEN-1:0] inst_address;
   logic            ce;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic            misaligned;

   modport master (
      input  stall_from_inst_if,
      input  stall_from_backend,
      input  redirect_valid,
      input  redirect_target,
      output inst_address,
      output ce,
      output if_valid,
      output if_pc,
      output misaligned
   );

   modport slave (
      output stall_from_inst_if,
      output stall_from_backend,
      output redirect_valid,
      output redirect_target,
      input  inst_address,
      input  ce,
      input  if_valid,
      input  if_pc,
      input  misaligned
   );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program counter owner ahead of the fetch stage.
// Ports: ACLK, ARESET (async, high); bus (pc_gen_if.master) carries
// inst_if/backend stalls, redirects, fetch address/enable, accept, fault.
module pc_gen #(
   parameter int                XLEN     = 64,
   parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic       ACLK,
   input  logic       ARESET,
   pc_gen_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GAP   = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t          state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic            redir_pend, redir_pend_n;
   logic [XLEN-1:0] redir_tgt, redir_tgt_n;
   logic            mis, mis_n;

   logic            done;
   logic            ld_en;
   logic [XLEN-1:0] ld_src;

   assign done = (state == REQ) & ~bus.stall_from_inst_if;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         redir_pend <= 1'b0;
         redir_tgt  <= '0;
         mis        <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         redir_pend <= redir_pend_n;
         redir_tgt  <= redir_tgt_n;
         mis        <= mis_n;
      end
   end

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      redir_pend_n = redir_pend;
      redir_tgt_n  = redir_tgt;
      mis_n        = mis;
      ld_en        = 1'b0;
      ld_src       = bus.redirect_target;

      unique case (state)
         IDLE, GAP: begin
            state_n = REQ;
            ld_en   = bus.redirect_valid;
         end
         REQ: begin
            if (!done) begin
               // Remember the latest redirect until the fetch retires.
               if (bus.redirect_valid) begin
                  redir_pend_n = 1'b1;
                  redir_tgt_n  = bus.redirect_target;
               end
            end else begin
               state_n      = GAP;
               redir_pend_n = 1'b0;
               if (bus.redirect_valid) begin
                  ld_en = 1'b1;
               end else if (redir_pend) begin
                  ld_en  = 1'b1;
                  ld_src = redir_tgt;
               end else if (!bus.stall_from_backend) begin
                  pc_n = pc + XLEN'(4);
               end
            end
         end
         FAULT: begin
            if (bus.redirect_valid) begin
               ld_en   = 1'b1;
               state_n = GAP;
            end
         end
      endcase

      // Any target load checks alignment; a bad one parks in FAULT.
      if (ld_en) begin
         pc_n = ld_src;
         if (|ld_src[1:0]) begin
            mis_n   = 1'b1;
            state_n = FAULT;
         end else begin
            mis_n = 1'b0;
         end
      end
   end

   assign bus.inst_address = pc;
   assign bus.ce           = (state == REQ);
   assign bus.if_pc        = pc;
   assign bus.misaligned   = mis;
   assign bus.if_valid     = done & ~redir_pend
                           & ~bus.redirect_valid
                           & ~bus.stall_from_backend;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: random stimulus for pc_gen checked against a
// behavioural model of fetch/redirect/fault rules.
module tb_pc_gen;

   localparam int          XLEN = 64;
   localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;

   logic ACLK;
   logic ARESET;
   int   n_tests;
   int   n_fail;

   pc_gen_if #(.XLEN(XLEN)) bus ();

   pc_gen #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus.master)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // model: fetching = a fetch request is open this cycle;
   // faulted = parked after a bad target; pend = deferred redirect
   bit          m_fetching;
   bit          m_faulted;
   bit          m_pend;
   logic [63:0] m_ptgt;
   logic [63:0] m_pc;
   bit          m_mis;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_fetching = 0;
      m_faulted  = 0;
      m_pend     = 0;
      m_ptgt     = '0;
      m_pc       = RPC;
      m_mis      = 0;
   endtask

   // returns 1 when the target was usable (aligned)
   function automatic bit m_load(input logic [63:0] t);
      m_pc = t;
      if (t[1:0] != 2'b00) begin
         m_mis      = 1;
         m_faulted  = 1;
         m_fetching = 0;
         return 0;
      end
      m_mis = 0;
      return 1;
   endfunction

   task automatic m_step(input bit si, input bit sb, input bit rv,
                         input logic [63:0] rt);
      bit ok;
      if (m_faulted) begin
         if (rv) begin
            ok = m_load(rt);
            if (ok) begin
               m_faulted  = 0;
               m_fetching = 0;
            end
         end
      end else if (!m_fetching) begin
         m_fetching = 1;
         if (rv) ok = m_load(rt);
      end else if (si) begin
         if (rv) begin
            m_pend = 1;
            m_ptgt = rt;
         end
      end else begin
         m_fetching = 0;
         if (rv) begin
            m_pend = 0;
            ok = m_load(rt);
         end else if (m_pend) begin
            m_pend = 0;
            ok = m_load(m_ptgt);
         end else if (!sb) begin
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   // called at negedge: drive, check, clock, update model
   task automatic step(input bit si, input bit sb, input bit rv,
                       input logic [63:0] rt);
      bit exp_v;
      bus.stall_from_inst_if = si;
      bus.stall_from_backend = sb;
      bus.redirect_valid     = rv;
      bus.redirect_target    = rt;
      #1;
      exp_v = m_fetching & !si & !m_pend & !rv & !sb;
      chk("ce", {63'd0, bus.ce}, {63'd0, m_fetching});
      chk("addr", bus.inst_address, m_pc);
      chk("if_valid", {63'd0, bus.if_valid}, {63'd0, exp_v});
      if (exp_v) chk("if_pc", bus.if_pc, m_pc);
      chk("mis", {63'd0, bus.misaligned}, {63'd0, m_mis});
      @(posedge ACLK);
      m_step(si, sb, rv, rt);
      @(negedge ACLK);
   endtask

   function automatic logic [63:0] rand_tgt();
      logic [63:0] t;
      int r;
      r = $urandom_range(0, 15);
      t = RPC + 64'($urandom_range(0, 1023)) * 64'd4;
      if (r == 0) t[1:0] = 2'($urandom_range(1, 3));
      else if (r == 1)
         t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
      return t;
   endfunction

   task automatic rand_steps(input int n);
      for (int i = 0; i < n; i++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, rand_tgt());
      end
   endtask

   task automatic mid_reset();
      #2;
      ARESET = 1'b1;
      #1;
      chk("rst_ce", {63'd0, bus.ce}, 64'd0);
      chk("rst_addr", bus.inst_address, RPC);
      chk("rst_mis", {63'd0, bus.misaligned}, 64'd0);
      bus.redirect_valid = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      ARESET = 1'b0;
      m_reset();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      ARESET  = 1'b1;
      bus.stall_from_inst_if = 1'b0;
      bus.stall_from_backend = 1'b0;
      bus.redirect_valid     = 1'b0;
      bus.redirect_target    = '0;
      m_reset();
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      chk("reset_ce", {63'd0, bus.ce}, 64'd0);
      chk("reset_addr", bus.inst_address, RPC);
      chk("reset_valid", {63'd0, bus.if_valid}, 64'd0);
      ARESET = 1'b0;

      // plain sequential run, zero-wait memory
      for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
      // slow memory, redirect during fetch, two redirects pending
      step(1, 0, 0, '0);
      step(1, 0, 1, 64'h8000_1000);
      step(1, 0, 1, 64'h8000_2000);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
      // backend stall then refetch
      step(0, 1, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
      // misaligned target, then aligned recovery
      step(0, 0, 1, 64'h8000_0102);
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
      step(0, 0, 1, 64'h8000_0200);
      for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
      // wrap at the top of the address space
      step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
      for (int i = 0; i < 8; i++) step(0, 0, 0, '0);

      for (int k = 0; k < 6; k++) begin
         rand_steps(500);
         mid_reset();
      end
      rand_steps(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
